// File: rtl/apb_mem_arbiter.sv
// Two-requester round-robin APB master: one SETUP/ACCESS transfer at a time, response routed back to the owner.
// Latency: grant +1 SETUP, +2 ACCESS, done pulse one cycle after pready (or after TIMEOUT ACCESS cycles).
module apb_mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic              r0_req,
    input  logic              r0_write,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_done,
    output logic [DATA_W-1:0] r0_rdata,
    output logic              r0_err,
    input  logic              r1_req,
    input  logic              r1_write,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_done,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              r1_err,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [DATA_W-1:0] pwdata,
    output logic              psel,
    output logic              penable,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);
    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, COMPLETE} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              owner;
    logic              prio;
    logic              grant;
    logic              any_req;
    logic              timeout_hit;
    logic              fin;
    logic [DATA_W-1:0] fin_rdata;
    logic              fin_err;
    logic [CNT_W-1:0]  tcnt;

    assign any_req     = r0_req | r1_req;
    // The priority pointer only matters when both requesters collide.
    assign grant       = (r0_req && r1_req) ? prio : r1_req;
    assign timeout_hit = (tcnt == CNT_LAST);
    assign fin         = (state == ACCESS) && (pready || timeout_hit);

    always_ff @(posedge pclk) begin
        if (prst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (any_req) state_nxt = SETUP;
            SETUP:    state_nxt = ACCESS;
            ACCESS:   if (pready || timeout_hit) state_nxt = COMPLETE;
            COMPLETE: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        psel    = (state == SETUP) || (state == ACCESS);
        penable = (state == ACCESS);
        r0_done = (state == COMPLETE) && !owner;
        r1_done = (state == COMPLETE) && owner;
    end

    // An abort (no pready) reports err=1 with zero data; writes never echo prdata.
    always_comb begin
        fin_rdata = '0;
        fin_err   = 1'b1;
        if (pready) begin
            fin_rdata = pwrite ? '0 : prdata;
            fin_err   = pslverr;
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            owner    <= 1'b0;
            prio     <= 1'b0;
            paddr    <= '0;
            pwrite   <= 1'b0;
            pwdata   <= '0;
            tcnt     <= '0;
            r0_rdata <= '0;
            r0_err   <= 1'b0;
            r1_rdata <= '0;
            r1_err   <= 1'b0;
        end else begin
            if (state == IDLE && any_req) begin
                owner  <= grant;
                prio   <= ~grant;
                paddr  <= grant ? r1_addr  : r0_addr;
                pwrite <= grant ? r1_write : r0_write;
                pwdata <= grant ? r1_wdata : r0_wdata;
                tcnt   <= '0;
            end
            if (state == ACCESS && !pready && !timeout_hit) begin
                tcnt <= tcnt + 1'b1;
            end
            if (fin && !owner) begin
                r0_rdata <= fin_rdata;
                r0_err   <= fin_err;
            end
            if (fin && owner) begin
                r1_rdata <= fin_rdata;
                r1_err   <= fin_err;
            end
        end
    end
endmodule

// File: tb/tb_apb_mem_arbiter.sv
// Randomized bench for apb_mem_arbiter with an APB slave model and a transaction-level scoreboard.
module tb_apb_mem_arbiter;
    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 16;

    logic          pclk = 1'b0;
    logic          prst;
    logic          r0_req, r0_write, r1_req, r1_write;
    logic [AW-1:0] r0_addr, r1_addr, paddr;
    logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, pwdata, prdata;
    logic          r0_done, r1_done, r0_err, r1_err;
    logic          pwrite, psel, penable, pready, pslverr;

    apb_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .prst(prst),
        .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_done(r0_done), .r0_rdata(r0_rdata), .r0_err(r0_err),
        .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_done(r1_done), .r1_rdata(r1_rdata), .r1_err(r1_err),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .psel(psel), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        bit       wr;
        bit [7:0] addr;
        bit [7:0] wdata;
        int       waits;
        bit       err;
    } req_t;

    typedef struct {
        bit       who;
        bit       wr;
        bit [7:0] addr;
        bit [7:0] wdata;
        bit [7:0] rdata;
        bit       err;
        int       acc;
    } exp_t;

    typedef struct {
        int waits;
        bit err;
    } plan_t;

    exp_t     exp_q[$];
    plan_t    plan_q[$];
    bit [7:0] mem_ref[256];
    bit [7:0] mem_slv[256];
    bit       ptr_ref = 1'b0;
    bit [7:0] last_rd[2];
    bit       last_err[2];
    int       checks = 0;
    int       failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic fail_evt(input string nm);
        checks++;
        failures++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    function automatic req_t mk(input bit wr, input bit [7:0] a, input bit [7:0] d,
                                input int w, input bit e);
        req_t r;
        r.wr = wr; r.addr = a; r.wdata = d; r.waits = w; r.err = e;
        return r;
    endfunction

    function automatic int acc_of(input int waits);
        return (waits >= TO) ? TO : waits + 1;
    endfunction

    // Transaction-level expectation: timeout if the slave stalls TIMEOUT or more cycles.
    function automatic void predict(input bit who, input req_t r);
        exp_t  e;
        plan_t p;
        bit    tmo;
        tmo     = (r.waits >= TO);
        e.who   = who;
        e.wr    = r.wr;
        e.addr  = r.addr;
        e.wdata = r.wdata;
        e.acc   = acc_of(r.waits);
        e.err   = tmo ? 1'b1 : r.err;
        e.rdata = (tmo || r.wr) ? 8'h00 : mem_ref[r.addr];
        if (r.wr && !tmo && !r.err) mem_ref[r.addr] = r.wdata;
        exp_q.push_back(e);
        p.waits = r.waits;
        p.err   = r.err;
        plan_q.push_back(p);
    endfunction

    // APB slave: waits per plan, random noise on prdata/pslverr whenever pready is low.
    int acc_cnt = 0;
    bit in_acc = 1'b0;
    always @(negedge pclk) begin
        pready  = 1'b0;
        pslverr = 1'($urandom);
        prdata  = 8'($urandom);
        if (psel && !penable) begin
            acc_cnt = 0;
            in_acc  = 1'b1;
        end else if (psel && penable && plan_q.size() > 0) begin
            if (acc_cnt == plan_q[0].waits) begin
                pready  = 1'b1;
                pslverr = plan_q[0].err;
                if (pwrite) begin
                    if (!plan_q[0].err) mem_slv[paddr] = pwdata;
                end else begin
                    prdata = mem_slv[paddr];
                end
                plan_q.delete(0);
                in_acc = 1'b0;
            end else begin
                acc_cnt++;
            end
        end else if (!psel && in_acc) begin
            in_acc = 1'b0;
            if (plan_q.size() > 0) plan_q.delete(0);
        end
    end

    // Monitor: bus fields at SETUP, stability during ACCESS, response at done.
    logic [16:0] s_fields;
    int          acc_seen = 0;
    int          setup_cyc = 0;
    int          cyc = 0;
    always @(negedge pclk) begin
        exp_t e;
        bit   who;
        cyc++;
        if (psel && !penable) begin
            if (exp_q.size() == 0) fail_evt("setup_unexpected");
            else chk("setup_fields", 32'({pwrite, paddr, pwdata}),
                     32'({exp_q[0].wr, exp_q[0].addr, exp_q[0].wdata}));
            s_fields  = {pwrite, paddr, pwdata};
            acc_seen  = 0;
            setup_cyc = cyc;
        end
        if (psel && penable) begin
            acc_seen++;
            chk("access_stable", 32'({pwrite, paddr, pwdata}), 32'(s_fields));
        end
        if (r0_done && r1_done) begin
            fail_evt("both_done");
        end else if (r0_done || r1_done) begin
            who = r1_done;
            if (exp_q.size() == 0) begin
                fail_evt("done_unexpected");
            end else begin
                e = exp_q.pop_front();
                chk("done_owner", 32'(who), 32'(e.who));
                chk("rdata", 32'(who ? r1_rdata : r0_rdata), 32'(e.rdata));
                chk("err", 32'(who ? r1_err : r0_err), 32'(e.err));
                chk("access_cycles", 32'(acc_seen), 32'(e.acc));
                chk("setup_to_done", 32'(cyc - setup_cyc), 32'(e.acc + 1));
                chk("other_rdata", 32'(e.who ? r0_rdata : r1_rdata), 32'(last_rd[!e.who]));
                chk("other_err", 32'(e.who ? r0_err : r1_err), 32'(last_err[!e.who]));
                last_rd[e.who]  = e.rdata;
                last_err[e.who] = e.err;
            end
        end
    end

    task automatic round(input bit en0, input bit en1, input req_t q0, input req_t q1);
        bit first;
        bit done0, done1;
        bit lat_done;
        int first_acc;
        if (en0 && en1) begin
            first = ptr_ref;
        end else begin
            first   = en1;
            ptr_ref = !en1;
        end
        if (first) begin
            predict(1'b1, q1);
            if (en0) predict(1'b0, q0);
        end else begin
            predict(1'b0, q0);
            if (en1) predict(1'b1, q1);
        end
        first_acc = acc_of(first ? q1.waits : q0.waits);
        @(negedge pclk);
        r0_req = en0; r0_write = q0.wr; r0_addr = q0.addr; r0_wdata = q0.wdata;
        r1_req = en1; r1_write = q1.wr; r1_addr = q1.addr; r1_wdata = q1.wdata;
        done0 = !en0;
        done1 = !en1;
        lat_done = 1'b0;
        for (int c = 1; c < 200 && !(done0 && done1); c++) begin
            @(negedge pclk);
            if (!lat_done && (first ? r1_done : r0_done)) begin
                chk("req_to_done", 32'(c), 32'(first_acc + 2));
                lat_done = 1'b1;
            end
            if (!done0 && r0_done) begin done0 = 1'b1; r0_req = 1'b0; end
            if (!done1 && r1_done) begin done1 = 1'b1; r1_req = 1'b0; end
        end
        if (!(done0 && done1)) begin
            fail_evt("round_timeout");
            r0_req = 1'b0;
            r1_req = 1'b0;
        end
    endtask

    function automatic req_t rnd_req();
        int k;
        int w;
        k = $urandom_range(0, 9);
        w = (k == 0) ? $urandom_range(15, 20) : $urandom_range(0, 3);
        return mk(1'($urandom), 8'($urandom_range(0, 15)), 8'($urandom), w,
                  ($urandom_range(0, 4) == 0));
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        req_t z;
        bit   en0, en1;
        z = mk(1'b0, 8'h00, 8'h00, 0, 1'b0);
        for (int i = 0; i < 256; i++) begin
            mem_ref[i] = 8'($urandom);
            mem_slv[i] = mem_ref[i];
        end
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        last_err[0] = 1'b0; last_err[1] = 1'b0;
        prst = 1'b1;
        r0_req = 1'b0; r0_write = 1'b0; r0_addr = '0; r0_wdata = '0;
        r1_req = 1'b0; r1_write = 1'b0; r1_addr = '0; r1_wdata = '0;
        repeat (3) @(negedge pclk);
        chk("reset_bus", 32'({psel, penable, pwrite, paddr, pwdata}), 32'(0));
        chk("reset_resp", 32'({r0_done, r0_rdata, r0_err, r1_done, r1_rdata, r1_err}), 32'(0));
        prst = 1'b0;

        // Collision straight after reset: r0 first, then r1.
        round(1'b1, 1'b1, mk(1'b0, 8'd3, 8'h11, 0, 1'b0), mk(1'b1, 8'd7, 8'h3C, 0, 1'b0));
        round(1'b1, 1'b1, mk(1'b0, 8'd7, 8'h22, 0, 1'b0), mk(1'b0, 8'd3, 8'h33, 1, 1'b0));
        round(1'b1, 1'b0, mk(1'b1, 8'd5, 8'hA5, 0, 1'b0), z);
        round(1'b1, 1'b0, mk(1'b0, 8'd5, 8'h00, 0, 1'b0), z);
        round(1'b0, 1'b1, z, mk(1'b1, 8'd9, 8'h5A, 0, 1'b0));
        round(1'b1, 1'b0, mk(1'b0, 8'd9, 8'h00, 3, 1'b0), z);
        round(1'b0, 1'b1, z, mk(1'b0, 8'd9, 8'h00, 0, 1'b1));
        round(1'b1, 1'b0, mk(1'b0, 8'd5, 8'h00, 1000, 1'b0), z);
        round(1'b0, 1'b1, z, mk(1'b0, 8'd5, 8'h00, TO - 1, 1'b0));
        round(1'b1, 1'b0, mk(1'b1, 8'd5, 8'hEE, TO, 1'b0), z);
        round(1'b0, 1'b1, z, mk(1'b0, 8'd5, 8'h00, 0, 1'b0));

        for (int n = 0; n < 80; n++) begin
            en0 = 1'($urandom);
            en1 = 1'($urandom);
            if (!en0 && !en1) en0 = 1'b1;
            round(en0, en1, rnd_req(), rnd_req());
            repeat ($urandom_range(0, 2)) @(negedge pclk);
        end

        // Reset mid-ACCESS with the pointer aimed at r1; afterwards r0 must win again.
        round(1'b1, 1'b0, mk(1'b0, 8'd2, 8'h00, 0, 1'b0), z);
        predict(1'b0, mk(1'b0, 8'd4, 8'h00, 1000, 1'b0));
        @(negedge pclk);
        r0_req = 1'b1; r0_write = 1'b0; r0_addr = 8'd4; r0_wdata = 8'h00;
        for (int c = 0; c < 20 && !penable; c++) @(negedge pclk);
        chk("reach_access", 32'(penable), 32'(1));
        @(negedge pclk);
        prst = 1'b1;
        exp_q.delete();
        @(negedge pclk);
        chk("rst_mid_bus", 32'({psel, penable}), 32'(0));
        chk("rst_mid_resp", 32'({r0_done, r0_rdata, r0_err, r1_done, r1_rdata, r1_err}), 32'(0));
        r0_req = 1'b0;
        prst = 1'b0;
        last_rd[0] = 8'h00; last_rd[1] = 8'h00;
        last_err[0] = 1'b0; last_err[1] = 1'b0;
        ptr_ref = 1'b0;
        repeat (3) @(negedge pclk);
        plan_q.delete();
        chk("idle_after_rst", 32'({psel, penable}), 32'(0));
        round(1'b1, 1'b1, mk(1'b0, 8'd5, 8'h00, 0, 1'b0), mk(1'b1, 8'd6, 8'h77, 2, 1'b0));

        repeat (5) @(negedge pclk);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/apb_mem_arbiter.md
Name: apb_mem_arbiter

Overview:
Two-requester APB master that shares one APB memory slave between two clients. It arbitrates round-robin and runs one APB transfer at a time (SETUP then ACCESS). It returns read data and error status to the owning requester. It sits between client logic (for example a DMA engine and a CPU-side port) and the apb_memory slave.

Parameters:
ADDR_W, 8, width of paddr and the requester addresses
DATA_W, 8, width of pwdata, prdata and the requester data
TIMEOUT, 16, number of ACCESS cycles without pready before the transfer is aborted (must be at least 2)

Ports:
pclk  input  1  clock; all logic on the rising edge
prst  input  1  synchronous active-high reset
r0_req  input  1  requester 0 transfer request; hold high with fields stable until r0_done
r0_write  input  1  1 = write, 0 = read
r0_addr  input  ADDR_W  requester 0 address
r0_wdata  input  DATA_W  requester 0 write data
r0_done  output  1  one-cycle pulse when requester 0's transfer ends
r0_rdata  output  DATA_W  read data, valid while r0_done is high
r0_err  output  1  error flag, valid while r0_done is high
r1_req, r1_write, r1_addr, r1_wdata, r1_done, r1_rdata, r1_err  same as r0_*, for requester 1
paddr  output  ADDR_W  APB address
pwrite  output  1  APB direction
pwdata  output  DATA_W  APB write data
psel  output  1  APB select
penable  output  1  APB enable
prdata  input  DATA_W  APB read data
pready  input  1  APB ready
pslverr  input  1  APB slave error

Behaviour:
- Reset: a synchronous reset with prst high forces state IDLE. It clears psel, penable, pwrite, paddr, pwdata, rN_done, rN_rdata, rN_err and the timeout counter to 0. It sets the priority pointer to requester 0. Reset mid-transfer abandons the transfer with no done pulse, and psel is 0 from the next cycle.
- FSM states: IDLE, SETUP, ACCESS, COMPLETE.
- IDLE:
  - If any rN_req is high, pick the owner, latch that requester's addr, write and wdata into paddr, pwrite and pwdata, then go to SETUP.
  - Otherwise stay in IDLE with psel=0 and penable=0.
- Arbitration:
  - A single requester wins outright.
  - If both are requesting, the requester named by the priority pointer wins.
  - After each grant, the pointer moves to the non-granted requester.
- SETUP: psel=1, penable=0, lasts exactly one cycle, then go to ACCESS.
- ACCESS: psel=1, penable=1.
  - If pready is sampled high, capture prdata (reads only; writes return 0) and pslverr into the owner's rdata and err registers, then go to COMPLETE.
  - Otherwise increment the timeout counter.
  - If the counter reaches TIMEOUT-1 without pready, abort: rdata=0, err=1, go to COMPLETE.
- COMPLETE:
  - psel=0 and penable=0.
  - The owner's rN_done is high for exactly this one cycle, with rdata and err valid.
  - No grant is made in this cycle. Next state is IDLE.
- Latency with zero wait states: req high in IDLE gives SETUP at +1, ACCESS at +2, and done at +3. A back-to-back transfer therefore costs 4 cycles.
- paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS.
- The non-owner's done, rdata and err stay 0 / unchanged throughout a transfer.
- Requester protocol:
  - A requester that drops req mid-transfer does not cancel it; the transfer completes and done still pulses.
  - A requester that keeps req high after done is treated as making a new request in the following IDLE cycle.
- pslverr is ignored unless pready is high.
- The timeout counter is cleared on entry to SETUP.

Test Plan:
- Single write then read, pready tied 1: r0 writes addr 5 / 0xA5, then r0 reads addr 5. Required: psel high for 2 cycles each, r0_done 3 cycles after req, r0_rdata=0xA5, r0_err=0.
- Simultaneous requests: r0 reads addr 3, r1 writes addr 7 / 0x3C, both held until done. Required: r0 served first after reset, then r1, with grants alternating and each done pulsing once.
- Wait states: pready low for 3 ACCESS cycles, then high with prdata=0x5A. Required: penable high for 4 cycles, paddr stable throughout, rdata=0x5A, done follows one cycle after pready.
- Slave error: pready=1, pslverr=1 on an r1 read. Required: r1_err=1 with r1_done, r0 outputs unaffected.
- Timeout: pready held 0 with TIMEOUT=16. Required: abort after 16 ACCESS cycles, done pulses with err=1, rdata=0, FSM back in IDLE.
- Reset mid-ACCESS: assert prst while penable=1. Required: psel=0 and penable=0 from the next cycle, no done pulse, priority pointer back to r0.
